// File: rtl/esc_pkg.sv
// esc_pkg: shared defaults and types for the ESC pulse generators.
// Default timing assumes a 50 MHz clock: 5.24 ms period, 1.00 ms minimum pulse.
package esc_pkg;

    // Width of the motor speed word coming from flght_cntrl.
    localparam int unsigned SPD_W = 11;

    // Default generator configuration.
    localparam int unsigned ESC_PERIOD_CYC = 262144;
    localparam int unsigned ESC_CNT_W      = 18;
    localparam int unsigned ESC_MIN_PULSE  = 50000;
    localparam int unsigned ESC_SCALE      = 3;
    localparam int unsigned ESC_SPD_MAX    = 2047;
    localparam int unsigned ESC_SLEW_STEP  = 1024;

    typedef logic [SPD_W-1:0] spd_t;

endpackage

// File: rtl/esc_slew_lim.sv
// esc_slew_lim: combinational next-width computation for the slew-limited build.
// The module only exists when SLEW_LIMIT_EN is defined; otherwise this file is empty.
`ifdef SLEW_LIMIT_EN
module esc_slew_lim #(
    parameter int unsigned CNT_W     = 18,
    parameter int unsigned MIN_PULSE = 50000,
    parameter int unsigned SLEW_STEP = 1024
) (
    input  logic [CNT_W-1:0] cur_w,
    input  logic [CNT_W-1:0] target,
    output logic [CNT_W-1:0] next_w
);

    // One spare bit so cur_w + SLEW_STEP and target + SLEW_STEP cannot wrap.
    localparam int unsigned          EXT_W     = CNT_W + 1;
    localparam logic [EXT_W-1:0]     STEP      = EXT_W'(SLEW_STEP);
    localparam logic [EXT_W-1:0]     START_CAP = EXT_W'(MIN_PULSE + SLEW_STEP);

    logic [EXT_W-1:0] cur_x;
    logic [EXT_W-1:0] tgt_x;
    logic [EXT_W-1:0] up_lim;
    logic [EXT_W-1:0] dn_ref;

    // Move cur_w toward target by at most STEP; stop and restart-from-idle are special.
    always_comb begin
        cur_x  = {1'b0, cur_w};
        tgt_x  = {1'b0, target};
        up_lim = cur_x + STEP;
        dn_ref = tgt_x + STEP;
        next_w = target;
        if (target == '0) begin
            next_w = '0;
        end else if (cur_w == '0) begin
            // Ramp from idle starts at the minimum pulse, never from zero width.
            next_w = (tgt_x > START_CAP) ? CNT_W'(START_CAP) : target;
        end else if (tgt_x > up_lim) begin
            next_w = CNT_W'(up_lim);
        end else if (dn_ref < cur_x) begin
            next_w = CNT_W'(cur_x - STEP);
        end else begin
            next_w = target;
        end
    end

endmodule
`endif

// File: rtl/esc_pwm_gen.sv
// esc_pwm_gen: one ESC pulse generator, spd in, PWM pin out.
// Pulse width = MIN_PULSE + min(spd, SPD_MAX) * SCALE, latched only at period
// boundaries so a pulse is never truncated; motors_off forces the output low.
// Build option: define SLEW_LIMIT_EN to limit width changes to SLEW_STEP cycles
// per period (instantiates esc_slew_lim); without it the width jumps directly.
module esc_pwm_gen
    import esc_pkg::*;
#(
    parameter int unsigned PERIOD_CYC = ESC_PERIOD_CYC,
    parameter int unsigned CNT_W      = ESC_CNT_W,
    parameter int unsigned MIN_PULSE  = ESC_MIN_PULSE,
    parameter int unsigned SCALE      = ESC_SCALE,
    parameter int unsigned SPD_MAX    = ESC_SPD_MAX,
    parameter int unsigned SLEW_STEP  = ESC_SLEW_STEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SPD_W-1:0] spd,
    input  logic             motors_off,
    output logic             pwm,
    output logic             period_strt,
    output logic [CNT_W-1:0] pulse_w
);

    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(PERIOD_CYC - 1);
    localparam spd_t             SPD_CLAMP  = SPD_W'(SPD_MAX);
    localparam logic [CNT_W-1:0] MIN_W      = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] SCALE_W    = CNT_W'(SCALE);
    localparam longint unsigned  CNT_RANGE  = 64'd1 << CNT_W;
    localparam longint unsigned  MAX_TARGET = 64'(MIN_PULSE) + 64'(SPD_MAX) * 64'(SCALE);

    // Configuration sanity: counter must hold the period, widths must fit in it.
    if (64'(PERIOD_CYC) > CNT_RANGE) begin : g_bad_period
        $error("esc_pwm_gen: PERIOD_CYC does not fit in CNT_W bits");
    end
    if (MAX_TARGET >= 64'(PERIOD_CYC)) begin : g_bad_target
        $error("esc_pwm_gen: maximum pulse width does not fit in the period");
    end
    if (64'(MIN_PULSE) + 64'(SLEW_STEP) >= CNT_RANGE) begin : g_bad_step
        $error("esc_pwm_gen: MIN_PULSE + SLEW_STEP does not fit in CNT_W bits");
    end

    logic [CNT_W-1:0] cnt;
    logic             at_last;
    spd_t             spd_q;
    logic [CNT_W-1:0] target;
    logic [CNT_W-1:0] target_calc;
    logic [CNT_W-1:0] next_w;

    // Period boundary detect and speed-to-width conversion of the S1 value.
    always_comb begin
        at_last     = (cnt == LAST_CNT);
        target_calc = MIN_W + CNT_W'(spd_q) * SCALE_W;
    end

`ifdef SLEW_LIMIT_EN
    esc_slew_lim #(
        .CNT_W     (CNT_W),
        .MIN_PULSE (MIN_PULSE),
        .SLEW_STEP (SLEW_STEP)
    ) u_slew_lim (
        .cur_w  (pulse_w),
        .target (target),
        .next_w (next_w)
    );
`else
    // Without slew limiting the shadow register takes the target directly.
    always_comb begin
        next_w = target;
    end
`endif

    // Free-running period counter 0..PERIOD_CYC-1 with a strobe as it wraps to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            period_strt <= 1'b0;
        end else begin
            cnt         <= at_last ? '0 : cnt + CNT_W'(1);
            period_strt <= at_last;
        end
    end

    // Two-stage input pipeline: clamp speed, then convert to a target width.
    always_ff @(posedge clk) begin
        if (rst) begin
            spd_q  <= '0;
            target <= '0;
        end else begin
            spd_q  <= (spd > SPD_CLAMP) ? SPD_CLAMP : spd;
            target <= motors_off ? '0 : target_calc;
        end
    end

    // Shadow width register: loads only at the period boundary, motors_off clears it at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_w <= '0;
        end else if (motors_off) begin
            pulse_w <= '0;
        end else if (at_last) begin
            pulse_w <= next_w;
        end
    end

    // Registered PWM pin, high for the first pulse_w counts of each period.
    always_ff @(posedge clk) begin
        if (rst || motors_off) begin
            pwm <= 1'b0;
        end else begin
            pwm <= (cnt < pulse_w);
        end
    end

endmodule

// File: tb/tb_esc_pwm_gen.sv
// tb_esc_pwm_gen: self-checking bench for esc_pwm_gen with a short 1000-cycle period.
// Expected widths are queued when speed stimulus is applied and compared against
// the measured high time of each completed PWM period.
module tb_esc_pwm_gen;

    localparam int unsigned PER  = 1000;
    localparam int unsigned CW   = 10;
    localparam int unsigned MINP = 100;
    localparam int unsigned SC   = 1;
    localparam int unsigned SMAX = 400;
    localparam int unsigned STEP = 50;
    localparam int unsigned TMO  = 3 * PER;
`ifdef SLEW_LIMIT_EN
    localparam bit SLEW = 1'b1;
`else
    localparam bit SLEW = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [10:0]   spd;
    logic          motors_off;
    logic          pwm;
    logic          period_strt;
    logic [CW-1:0] pulse_w;

    esc_pwm_gen #(
        .PERIOD_CYC (PER),
        .CNT_W      (CW),
        .MIN_PULSE  (MINP),
        .SCALE      (SC),
        .SPD_MAX    (SMAX),
        .SLEW_STEP  (STEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spd         (spd),
        .motors_off  (motors_off),
        .pwm         (pwm),
        .period_strt (period_strt),
        .pulse_w     (pulse_w)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned hc;
        int unsigned pw;
        int unsigned len;
        bit          clean;
    } win_t;

    win_t        meas_q[$];
    int unsigned exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    int unsigned tb_cnt   = 0;
    bit          synced   = 1'b0;
    int unsigned cur_w    = 0;
    event        mon_ev;

    // Reference behaviour: target width from speed, and the boundary width update.
    function automatic int unsigned model_target(input int unsigned s);
        int unsigned c;
        c = (s > SMAX) ? SMAX : s;
        return MINP + c * SC;
    endfunction

    function automatic int unsigned model_next(input int unsigned cur, input int unsigned tgt);
        if (!SLEW) return tgt;
        if (tgt == 0) return 0;
        if (cur == 0) return (tgt < MINP + STEP) ? tgt : MINP + STEP;
        if (tgt > cur + STEP) return cur + STEP;
        if (tgt + STEP < cur) return cur - STEP;
        return tgt;
    endfunction

    // Period monitor: a window runs from the cycle after period_strt up to and
    // including the next period_strt (pwm lags the counter by one cycle).
    int unsigned m_hc, m_len, m_pw;
    bit          m_in, m_clean;
    always @(negedge clk) begin
        if (rst) begin
            m_in   = 1'b0;
            synced = 1'b0;
        end else if (period_strt === 1'b1) begin
            if (m_in) begin
                if (pwm === 1'b1) m_hc++;
                m_len++;
                n_checks++;
                if (m_len != PER) begin
                    n_fail++;
                    $display("FAIL period_len: %0d cycles between strobes, expected %0d", m_len, PER);
                end
                if (m_clean) begin
                    n_checks++;
                    if (m_hc != m_pw) begin
                        n_fail++;
                        $display("FAIL high_vs_pulse_w: pwm high %0d cycles, pulse_w was %0d", m_hc, m_pw);
                    end
                end
                meas_q.push_back('{m_hc, m_pw, m_len, m_clean});
            end
            m_in    = 1'b1;
            m_hc    = 0;
            m_len   = 0;
            m_pw    = pulse_w;
            m_clean = 1'b1;
            tb_cnt  = 0;
            synced  = 1'b1;
        end else begin
            if (m_in) begin
                if (pwm === 1'b1) m_hc++;
                m_len++;
                if (motors_off) m_clean = 1'b0;
            end
            tb_cnt++;
        end
        -> mon_ev;
    end

    task automatic wait_cnt(input int unsigned k);
        int unsigned n = 0;
        do begin
            @(mon_ev);
            n++;
        end while (!(synced && tb_cnt == k) && n < TMO);
        if (!(synced && tb_cnt == k)) begin
            n_checks++;
            n_fail++;
            $display("FAIL sync_cnt: counter value %0d not reached within %0d cycles", k, TMO);
        end
    endtask

    task automatic get_win(output win_t w, output bit ok);
        int unsigned n = 0;
        while (meas_q.size() == 0 && n < TMO) begin
            @(mon_ev);
            n++;
        end
        ok = (meas_q.size() != 0);
        if (ok) w = meas_q.pop_front();
        else    w = '{0, 0, 0, 1'b0};
    endtask

    // Drive a new speed at mid-period; queue the unchanged current width and the next one.
    task automatic apply_at_mid(input int unsigned s);
        wait_cnt(500);
        meas_q.delete();
        spd = 11'(s);
        exp_q.push_back(cur_w);
        cur_w = model_next(cur_w, model_target(s));
        exp_q.push_back(cur_w);
    endtask

    task automatic test_reset();
        int unsigned n, hi, e;
        win_t        w;
        bit          ok;
        rst        = 1'b1;
        spd        = '0;
        motors_off = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(mon_ev);
            n_checks++;
            if (pwm !== 1'b0 || period_strt !== 1'b0 || pulse_w !== '0) begin
                n_fail++;
                $display("FAIL reset_state: pwm=%b period_strt=%b pulse_w=%0d, expected 0/0/0", pwm, period_strt, pulse_w);
            end
        end
        rst = 1'b0;
        n   = 0;
        hi  = 0;
        do begin
            @(mon_ev);
            n++;
            if (pwm === 1'b1) hi++;
        end while (period_strt !== 1'b1 && n < TMO);
        n_checks++;
        if (n != PER) begin
            n_fail++;
            $display("FAIL first_strobe: period_strt after %0d cycles, expected %0d", n, PER);
        end
        n_checks++;
        if (hi != 0) begin
            n_fail++;
            $display("FAIL first_period_low: pwm high %0d cycles with pulse_w 0, expected 0", hi);
        end
        meas_q.delete();
        cur_w = model_next(0, model_target(0));
        exp_q.push_back(cur_w);
        cur_w = model_next(cur_w, model_target(0));
        exp_q.push_back(cur_w);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            get_win(w, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL idle_width: no period completed, expected width %0d", e);
            end else if (w.hc != e) begin
                n_fail++;
                $display("FAIL idle_width: pwm high %0d cycles, expected %0d", w.hc, e);
            end
        end
    endtask

    task automatic test_spd_change();
        int unsigned e;
        win_t        w;
        bit          ok;
        apply_at_mid(300);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            get_win(w, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL spd_change_width: no period completed, expected width %0d", e);
            end else if (w.hc != e) begin
                n_fail++;
                $display("FAIL spd_change_width: pwm high %0d cycles, expected %0d", w.hc, e);
            end
        end
    endtask

    task automatic test_clamp();
        int unsigned e;
        win_t        w;
        bit          ok;
        int unsigned tbl[4] = '{2047, 2000, 401, 400};
        foreach (tbl[i]) begin
            apply_at_mid(tbl[i]);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                get_win(w, ok);
                n_checks++;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL clamp_width: spd %0d, no period completed, expected width %0d", tbl[i], e);
                end else if (w.hc != e) begin
                    n_fail++;
                    $display("FAIL clamp_width: spd %0d, pwm high %0d cycles, expected %0d", tbl[i], w.hc, e);
                end
            end
        end
        @(mon_ev);
        n_checks++;
        if (pulse_w !== CW'(cur_w)) begin
            n_fail++;
            $display("FAIL clamp_pulse_w: pulse_w %0d, expected %0d", pulse_w, cur_w);
        end
    endtask

    task automatic test_motors_off();
        int unsigned e;
        win_t        w;
        bit          ok;
        apply_at_mid(300);
        while (cur_w != model_target(300)) begin
            cur_w = model_next(cur_w, model_target(300));
            exp_q.push_back(cur_w);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            get_win(w, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL off_settle: no period completed, expected width %0d", e);
            end else if (w.hc != e) begin
                n_fail++;
                $display("FAIL off_settle: pwm high %0d cycles, expected %0d", w.hc, e);
            end
        end
        wait_cnt(50);
        meas_q.delete();
        motors_off = 1'b1;
        @(mon_ev);
        n_checks++;
        if (pwm !== 1'b0 || pulse_w !== '0) begin
            n_fail++;
            $display("FAIL off_immediate: pwm=%b pulse_w=%0d, expected 0/0", pwm, pulse_w);
        end
        motors_off = 1'b0;
        wait_cnt(998);
        n_checks++;
        if (pulse_w !== '0) begin
            n_fail++;
            $display("FAIL off_release_hold: pulse_w %0d before boundary, expected 0", pulse_w);
        end
        exp_q.push_back(50);
        cur_w = model_next(0, model_target(300));
        exp_q.push_back(cur_w);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            get_win(w, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL off_width: no period completed, expected width %0d", e);
            end else if (w.hc != e) begin
                n_fail++;
                $display("FAIL off_width: pwm high %0d cycles, expected %0d", w.hc, e);
            end
        end
    endtask

`ifdef SLEW_LIMIT_EN
    task automatic test_slew_ramp();
        int unsigned e;
        win_t        w;
        bit          ok;
        int unsigned up[6] = '{150, 200, 250, 300, 350, 400};
        int unsigned dn[6] = '{350, 300, 250, 200, 150, 100};
        apply_at_mid(0);
        while (cur_w != MINP) begin
            cur_w = model_next(cur_w, MINP);
            exp_q.push_back(cur_w);
        end
        wait_cnt(500);
        meas_q.delete();
        spd = 11'd300;
        exp_q.push_back(100);
        foreach (up[i]) exp_q.push_back(up[i]);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            get_win(w, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL slew_up: no period completed, expected width %0d", e);
            end else if (w.hc != e) begin
                n_fail++;
                $display("FAIL slew_up: pwm high %0d cycles, expected %0d", w.hc, e);
            end
        end
        wait_cnt(500);
        meas_q.delete();
        spd = 11'd0;
        exp_q.push_back(400);
        foreach (dn[i]) exp_q.push_back(dn[i]);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            get_win(w, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL slew_down: no period completed, expected width %0d", e);
            end else if (w.hc != e) begin
                n_fail++;
                $display("FAIL slew_down: pwm high %0d cycles, expected %0d", w.hc, e);
            end
        end
        cur_w = 100;
    endtask

    task automatic test_slew_from_off();
        int unsigned e;
        win_t        w;
        bit          ok;
        int unsigned up[6] = '{150, 200, 250, 300, 350, 400};
        wait_cnt(500);
        meas_q.delete();
        spd        = 11'd300;
        motors_off = 1'b1;
        exp_q.push_back(100);
        foreach (up[i]) exp_q.push_back(up[i]);
        wait_cnt(900);
        motors_off = 1'b0;
        n_checks++;
        if (pulse_w !== '0) begin
            n_fail++;
            $display("FAIL slew_off_hold: pulse_w %0d while off, expected 0", pulse_w);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            get_win(w, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL slew_from_off: no period completed, expected width %0d", e);
            end else if (w.hc != e) begin
                n_fail++;
                $display("FAIL slew_from_off: pwm high %0d cycles, expected %0d", w.hc, e);
            end
        end
        cur_w = 400;
    endtask
`endif

    task automatic test_reset_mid();
        int unsigned n, e;
        win_t        w;
        bit          ok;
        wait_cnt(50);
        meas_q.delete();
        rst = 1'b1;
        @(mon_ev);
        n_checks++;
        if (pwm !== 1'b0 || pulse_w !== '0 || period_strt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_pulse: pwm=%b pulse_w=%0d period_strt=%b, expected 0/0/0", pwm, pulse_w, period_strt);
        end
        rst = 1'b0;
        n   = 0;
        do begin
            @(mon_ev);
            n++;
        end while (period_strt !== 1'b1 && n < TMO);
        n_checks++;
        if (n != PER) begin
            n_fail++;
            $display("FAIL reset_mid_strobe: period_strt after %0d cycles, expected %0d", n, PER);
        end
        meas_q.delete();
        cur_w = model_next(0, model_target(300));
        exp_q.push_back(cur_w);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            get_win(w, ok);
            n_checks++;
            if (!ok) begin
                n_fail++;
                $display("FAIL reset_mid_width: no period completed, expected width %0d", e);
            end else if (w.hc != e) begin
                n_fail++;
                $display("FAIL reset_mid_width: pwm high %0d cycles, expected %0d", w.hc, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_spd_change();
        test_clamp();
        test_motors_off();
`ifdef SLEW_LIMIT_EN
        test_slew_ramp();
        test_slew_from_off();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
